// File: rtl/my_pkg.sv
// Shared ifetch definitions: datapath width, default reset PC and FSM state type.
package my_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_REQ   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_ERR   = 3'd4
    } ifetch_state_t;

endpackage

// File: rtl/rv_ifetch.sv
// Instruction fetch: one outstanding imem request, PC and instruction registers.
// Define RV_IFETCH_MISALIGN_CHECK_EN to fault on a PC with nonzero low bits.
module rv_ifetch #(
    parameter int                    DATA_WIDTH = my_pkg::DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(my_pkg::RESET_PC_DEF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] nextpc,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] flush_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  fetch_err
);

    import my_pkg::*;

    ifetch_state_t state;
    ifetch_state_t state_d;
    logic          misalign;
    logic          req_fire;
    logic          inst_fire;

`ifdef RV_IFETCH_MISALIGN_CHECK_EN
    assign misalign  = |pc_o[1:0];
    assign fetch_err = !rst && (state == ST_ERR);
`else
    assign misalign  = 1'b0;
    assign fetch_err = 1'b0;
`endif

    assign imem_req_valid = !rst && (state == ST_REQ) && !misalign;
    assign imem_addr      = pc_o;
    assign inst_valid     = !rst && (state == ST_HOLD);
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign inst_fire      = inst_valid && inst_ready;

    // A flush that leaves a response owed parks in DRAIN until it returns.
    always_comb begin
        state_d = state;
        case (state)
            ST_REQ: begin
                if (flush)
                    state_d = req_fire ? ST_DRAIN : ST_REQ;
                else if (misalign)
                    state_d = ST_ERR;
                else if (req_fire)
                    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rsp_valid)
                    state_d = flush ? ST_REQ : ST_HOLD;
                else if (flush)
                    state_d = ST_DRAIN;
            end
            ST_HOLD: begin
                if (flush || inst_ready)
                    state_d = ST_REQ;
            end
            ST_DRAIN: begin
                if (flush || imem_rsp_valid)
                    state_d = ST_REQ;
            end
            ST_ERR: begin
                if (flush)
                    state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_REQ;
            pc_o  <= RESET_PC;
            inst  <= '0;
        end else begin
            state <= state_d;
            if (flush)
                pc_o <= flush_pc;
            else if (inst_fire)
                pc_o <= nextpc;
            if (state == ST_WAIT && imem_rsp_valid && !flush)
                inst <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_rv_ifetch.sv
// Self-checking bench for rv_ifetch: directed scenarios plus randomized traffic
// against a transaction-level PC/instruction model and a latency-modelled memory.
module tb_rv_ifetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] nextpc = '0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc_o;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    rv_ifetch #(
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0000_1000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .nextpc        (nextpc),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .pc_o          (pc_o),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
    endfunction

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] data;
        int          due;
    } ent_t;

    ent_t        mq[$];
    int          cyc = 0;
    int          lat = 1;
    bit          dead_en = 1'b0;
    bit          s_acc, s_rsp, s_rst, s_dead;
    int          s_lat;
    logic [31:0] s_addr;

    always begin
        @(negedge clk);
        s_acc  = imem_req_valid && imem_req_ready;
        s_rsp  = imem_rsp_valid;
        s_addr = imem_addr;
        s_rst  = rst;
        s_lat  = lat;
        s_dead = dead_en;
        @(posedge clk);
        #1;
        cyc++;
        if (s_rst) begin
            mq.delete();
        end else begin
            if (s_rsp && mq.size() > 0)
                void'(mq.pop_front());
            if (s_acc)
                mq.push_back('{s_dead ? 32'hDEAD_BEEF : memf(s_addr),
                               cyc + s_lat - 1});
        end
        if (mq.size() > 0 && cyc >= mq[0].due) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq[0].data;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed tests ----------------
    task automatic test_reset;
        int n;
        rst = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        nextpc = 32'h0000_1004;
        lat = 1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (pc_o !== 32'h0000_1000) begin
            errors++;
            $display("FAIL reset_pc got %h exp %h", pc_o, 32'h0000_1000);
        end
        checks++;
        if (inst !== 32'h0) begin
            errors++;
            $display("FAIL reset_inst got %h exp 0", inst);
        end
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_inst_valid got %b exp 0", inst_valid);
        end
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_valid got %b exp 0", imem_req_valid);
        end
        checks++;
        if (fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_fetch_err got %b exp 0", fetch_err);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL first_req got v=%b a=%h exp v=1 a=%h",
                     imem_req_valid, imem_addr, 32'h0000_1000);
        end
        n = 0;
        while (!inst_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL first_inst_latency got %0d exp 2", n);
        end
        checks++;
        if (inst !== memf(32'h0000_1000) || pc_o !== 32'h0000_1000) begin
            errors++;
            $display("FAIL first_inst got %h/%h exp %h/%h",
                     inst, pc_o, memf(32'h0000_1000), 32'h0000_1000);
        end
    endtask

    task automatic test_cadence;
        int          ri[$];
        logic [31:0] ra[$];
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 0)
                nextpc = 32'h0000_2000;
            @(negedge clk);
            if (imem_req_valid) begin
                ri.push_back(i);
                ra.push_back(imem_addr);
            end
        end
        checks++;
        if (ri.size() != 3) begin
            errors++;
            $display("FAIL cadence_count got %0d exp 3", ri.size());
        end else begin
            checks++;
            if (ri[0] != 0 || ra[0] !== 32'h0000_1004) begin
                errors++;
                $display("FAIL cadence_req0 got c%0d a=%h exp c0 a=%h",
                         ri[0], ra[0], 32'h0000_1004);
            end
            checks++;
            if (ri[1] != 3 || ra[1] !== 32'h0000_2000) begin
                errors++;
                $display("FAIL cadence_req1 got c%0d a=%h exp c3 a=%h",
                         ri[1], ra[1], 32'h0000_2000);
            end
            checks++;
            if (ri[2] != 6) begin
                errors++;
                $display("FAIL cadence_req2 got c%0d exp c6", ri[2]);
            end
        end
    endtask

    task automatic test_stall;
        int          n;
        logic [31:0] i0, p0;
        tick();
        inst_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!inst_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!inst_valid) begin
            errors++;
            $display("FAIL stall_wait got timeout exp inst_valid");
        end
        i0 = inst;
        p0 = pc_o;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (inst_valid !== 1'b1 || inst !== i0 || pc_o !== p0 ||
                imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold got v=%b i=%h p=%h rq=%b exp v=1 i=%h p=%h rq=0",
                         inst_valid, inst, pc_o, imem_req_valid, i0, p0);
            end
        end
        tick();
        inst_ready = 1'b1;
    endtask

    task automatic test_flush_wait;
        int          n;
        int          first;
        bit          seen;
        logic [31:0] fa;
        tick();
        lat = 3;
        dead_en = 1'b1;
        inst_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(imem_req_valid && imem_req_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        tick();
        flush = 1'b1;
        flush_pc = 32'h0000_0100;
        dead_en = 1'b0;
        lat = 1;
        tick();
        flush = 1'b0;
        first = -1;
        seen = 1'b0;
        fa = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (inst === 32'hDEAD_BEEF)
                seen = 1'b1;
            if (imem_req_valid && first < 0) begin
                first = i;
                fa = imem_addr;
            end
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_wait_discard got inst=DEADBEEF exp never");
        end
        checks++;
        if (fa !== 32'h0000_0100) begin
            errors++;
            $display("FAIL flush_wait_addr got %h exp %h", fa, 32'h0000_0100);
        end
        checks++;
        if (first != 2) begin
            errors++;
            $display("FAIL flush_wait_drain got c%0d exp c2", first);
        end
    endtask

    task automatic test_flush_hs;
        int n;
        tick();
        inst_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!inst_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        tick();
        inst_ready = 1'b1;
        nextpc = 32'h0000_0008;
        flush = 1'b1;
        flush_pc = 32'h0000_0200;
        tick();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0000_0200) begin
            errors++;
            $display("FAIL flush_hs_addr got v=%b a=%h exp v=1 a=%h",
                     imem_req_valid, imem_addr, 32'h0000_0200);
        end
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_hs_valid got %b exp 0", inst_valid);
        end
    endtask

`ifdef RV_IFETCH_MISALIGN_CHECK_EN
    task automatic test_misalign;
        tick();
        flush = 1'b1;
        flush_pc = 32'h0000_0102;
        tick();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL misalign_noreq got %b exp 0", imem_req_valid);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (fetch_err !== 1'b1 || imem_req_valid !== 1'b0 ||
                inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL misalign_err got e=%b rq=%b v=%b exp e=1 rq=0 v=0",
                         fetch_err, imem_req_valid, inst_valid);
            end
        end
        tick();
        flush = 1'b1;
        flush_pc = 32'h0000_0104;
        tick();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (fetch_err !== 1'b0 || imem_req_valid !== 1'b1 ||
            imem_addr !== 32'h0000_0104) begin
            errors++;
            $display("FAIL misalign_recover got e=%b rq=%b a=%h exp e=0 rq=1 a=%h",
                     fetch_err, imem_req_valid, imem_addr, 32'h0000_0104);
        end
    endtask
`else
    task automatic test_misalign;
        tick();
        flush = 1'b1;
        flush_pc = 32'h0000_0102;
        tick();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (fetch_err !== 1'b0 || imem_req_valid !== 1'b1 ||
            imem_addr !== 32'h0000_0102) begin
            errors++;
            $display("FAIL unaligned_passthru got e=%b rq=%b a=%h exp e=0 rq=1 a=%h",
                     fetch_err, imem_req_valid, imem_addr, 32'h0000_0102);
        end
    endtask
`endif

    // ---------------- randomized traffic ----------------
    task automatic test_random;
        logic [31:0] pc_model;
        bit          stale;
        bit          acc, rsp;
        int          owed, idle, delivered;
        tick();
        rst = 1'b1;
        flush = 1'b0;
        inst_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        pc_model = 32'h0000_1000;
        stale = 1'b0;
        idle = 0;
        delivered = 0;
        for (int k = 0; k < 2500; k++) begin
            inst_ready     = ($urandom % 4) != 0;
            imem_req_ready = ($urandom % 3) != 0;
            nextpc         = $urandom & 32'hFFFF_FFFC;
            flush_pc       = $urandom & 32'hFFFF_FFFC;
            flush          = !stale && (($urandom % 10) == 0);
            lat            = $urandom_range(1, 3);
            @(negedge clk);
            acc  = imem_req_valid && imem_req_ready;
            rsp  = imem_rsp_valid;
            owed = mq.size();
            if (imem_req_valid) begin
                checks++;
                if (owed != 0 || imem_addr !== pc_model || inst_valid) begin
                    errors++;
                    $display("FAIL rnd_req got a=%h owed=%0d v=%b exp a=%h owed=0 v=0",
                             imem_addr, owed, inst_valid, pc_model);
                end
            end
            if (inst_valid) begin
                checks++;
                if (pc_o !== pc_model || inst !== memf(pc_model)) begin
                    errors++;
                    $display("FAIL rnd_inst got %h/%h exp %h/%h",
                             inst, pc_o, memf(pc_model), pc_model);
                end
            end
            checks++;
            if (fetch_err !== 1'b0) begin
                errors++;
                $display("FAIL rnd_fetch_err got %b exp 0", fetch_err);
            end
            if (flush) begin
                stale = acc || (owed > 0 && !rsp);
                pc_model = flush_pc;
                idle = 0;
            end else begin
                if (rsp)
                    stale = 1'b0;
                if (inst_valid && inst_ready) begin
                    pc_model = nextpc;
                    delivered++;
                    idle = 0;
                end else begin
                    idle++;
                end
            end
            if (idle > 60) begin
                errors++;
                $display("FAIL rnd_progress got %0d idle cycles exp <=60", idle);
                break;
            end
            tick();
        end
        flush = 1'b0;
        checks++;
        if (delivered < 50) begin
            errors++;
            $display("FAIL rnd_delivered got %0d exp >=50", delivered);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_cadence();
        test_stall();
        test_flush_wait();
        test_flush_hs();
        test_misalign();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_ifetch.md
RV_IFETCH -- requirements
Module: rv_ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded by reset.
REQ-002 Parameter DATA_WIDTH, default package DATA_WIDTH (32), width of PC, address and instruction.
REQ-003 Clocking and reset SHALL be one clock, with synchronous active-high reset: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-004 nextpc  in  DATA_WIDTH  next PC from the next-PC generator, sampled on instruction handshake.
REQ-005 flush  in  1  redirect request (trap/exception), highest priority.
REQ-006 flush_pc  in  DATA_WIDTH  redirect target.
REQ-007 imem_req_valid  out  1; imem_req_ready  in  1; imem_addr  out  DATA_WIDTH — instruction memory request channel.
REQ-008 imem_rsp_valid  in  1; imem_rsp_data  in  DATA_WIDTH — instruction memory response; one response per accepted request, in order, at least 1 cycle after acceptance.
REQ-009 inst_valid  out  1; inst_ready  in  1; inst  out  DATA_WIDTH; pc_o  out  DATA_WIDTH — instruction to decode plus its PC.
REQ-010 fetch_err  out  1  misaligned-PC fault (only with REQ-024 macro).

Function
REQ-011 FSM states SHALL be REQ, WAIT, HOLD, DRAIN (plus ERR, macro only); at most one request outstanding.
REQ-012 REQ: imem_req_valid=1, imem_addr=pc_o; on imem_req_ready go WAIT.
REQ-013 WAIT: on imem_rsp_valid register imem_rsp_data into inst, go HOLD; inst_valid rises the cycle after rsp_valid.
REQ-014 HOLD: inst_valid=1, inst and pc_o stable; on inst_valid&inst_ready load pc_o<=nextpc, drop inst_valid next cycle, go REQ.
REQ-015 Minimum throughput SHALL be 3 cycles per instruction with ready memory and decoder (REQ→WAIT→HOLD).
REQ-016 flush in any state SHALL load pc_o<=flush_pc, clear inst_valid next cycle, and override a same-cycle instruction handshake (nextpc discarded).
REQ-017 flush in REQ without req_ready, or in HOLD/DRAIN/ERR → REQ.
REQ-018 flush in REQ with same-cycle req_ready, or in WAIT without rsp_valid → DRAIN (response still owed).
REQ-019 flush in WAIT with same-cycle rsp_valid: response discarded, go REQ.
REQ-020 DRAIN: imem_req_valid=0; on imem_rsp_valid discard data, go REQ.
REQ-021 imem_rsp_valid outside WAIT/DRAIN SHALL be ignored.
REQ-022 PC arithmetic SHALL be none internally; nextpc/flush_pc taken verbatim, full DATA_WIDTH, no wrap handling.

Reset
REQ-023 While rst=1: pc_o=RESET_PC, inst=0, inst_valid=0, imem_req_valid=0, fetch_err=0, state=REQ; first request issued in the first cycle after rst deasserts; rst mid-transaction abandons any outstanding response (memory is reset together).

Configuration
REQ-024 Macro RV_IFETCH_MISALIGN_CHECK_EN defined: in REQ, if pc_o[1:0]!=2'b00, no request issued, go ERR; ERR holds fetch_err=1, inst_valid=0, imem_req_valid=0 until flush or rst.
REQ-025 Macro undefined: no ERR state, fetch_err tied 0, pc_o[1:0] driven to imem_addr unchanged.

Structure
REQ-026 Shared package my_pkg SHALL hold DATA_WIDTH, the default RESET_PC constant and the ifetch state enum typedef.
REQ-027 No sub-module; single flat module with FSM, PC register and instruction register.

Verification
REQ-028 Reset with RESET_PC=32'h0000_1000, memory always ready, 1-cycle latency → imem_addr=32'h0000_1000 first cycle after reset, inst_valid 2 cycles later.
REQ-029 Handshake with nextpc=32'h0000_1004, then 32'h0000_2000 → next imem_addr values 32'h0000_1004, 32'h0000_2000; 3-cycle cadence.
REQ-030 inst_ready held low 5 cycles → inst/pc_o stable, no new request, imem_req_valid=0.
REQ-031 flush (flush_pc=32'h0000_0100) in WAIT, response arrives 2 cycles later with 32'hDEAD_BEEF → data never appears on inst; next imem_addr=32'h0000_0100.
REQ-032 Same-cycle flush and handshake (nextpc=32'h0000_0008, flush_pc=32'h0000_0200) → next imem_addr=32'h0000_0200.
REQ-033 Macro defined, flush_pc=32'h0000_0102 → fetch_err=1, no request; flush to 32'h0000_0104 → fetch_err=0, request at 32'h0000_0104.
